// File: rtl/riscv_hwloop_regs_if.sv
// Hardware-loop register file bus: write port, fetch/commit decrement control,
// and the stored loop state presented back to the controller.
interface riscv_hwloop_regs_if #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
);
  logic [31:0]                  hwlp_start_data_i;
  logic [31:0]                  hwlp_end_data_i;
  logic [31:0]                  hwlp_cnt_data_i;
  logic [2:0]                   hwlp_we_i;
  logic [N_REG_BITS-1:0]        hwlp_regid_i;
  logic [N_REGS-1:0]            hwlp_dec_cnt_i;
  logic                         valid_i;
  logic                         flush_i;
  logic [N_REGS-1:0][31:0]      hwlp_start_addr_o;
  logic [N_REGS-1:0][31:0]      hwlp_end_addr_o;
  logic [N_REGS-1:0][31:0]      hwlp_counter_o;
  logic [N_REGS-1:0]            hwlp_dec_cnt_id_o;
  logic [N_REGS-1:0]            hwlp_active_o;

  // Handshake: hwlp_dec_cnt_i marks a fetch-stage decrement request; it is held
  // pending until valid_i (ID retire) commits it or flush_i discards it. No ready.
  modport master (
    output hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_we_i,
           hwlp_regid_i, hwlp_dec_cnt_i, valid_i, flush_i,
    input  hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o,
           hwlp_dec_cnt_id_o, hwlp_active_o
  );

  modport slave (
    input  hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_we_i,
           hwlp_regid_i, hwlp_dec_cnt_i, valid_i, flush_i,
    output hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o,
           hwlp_dec_cnt_id_o, hwlp_active_o
  );
endinterface

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register sets: start/end/count storage with fetch-time
// decrement requests committed at ID retire, saturating at zero.
module riscv_hwloop_regs #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_hwloop_regs_if.slave   hw
);

  logic [N_REGS-1:0][31:0] start_q, start_d;
  logic [N_REGS-1:0][31:0] end_q, end_d;
  logic [N_REGS-1:0][31:0] cnt_q, cnt_d;
  logic [N_REGS-1:0]       pend_q, pend_d;

  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    for (int i = 0; i < N_REGS; i++) begin
      // Out-of-range register ids never match any set and are dropped.
      if ((int'(hw.hwlp_regid_i) == i) && hw.hwlp_we_i[0])
        start_d[i] = hw.hwlp_start_data_i;
      if ((int'(hw.hwlp_regid_i) == i) && hw.hwlp_we_i[1])
        end_d[i] = hw.hwlp_end_data_i;

      if (hw.flush_i)
        pend_d[i] = 1'b0;
      else if (hw.valid_i)
        pend_d[i] = hw.hwlp_dec_cnt_i[i];
      else
        pend_d[i] = pend_q[i] | hw.hwlp_dec_cnt_i[i];

      // A counter write overrides a same-cycle commit and drops the pending one.
      if ((int'(hw.hwlp_regid_i) == i) && hw.hwlp_we_i[2]) begin
        cnt_d[i]  = hw.hwlp_cnt_data_i;
        pend_d[i] = 1'b0;
      end else if (hw.valid_i && pend_q[i] && !hw.flush_i && (cnt_q[i] != 32'd0)) begin
        cnt_d[i] = cnt_q[i] - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign hw.hwlp_start_addr_o = start_q;
  assign hw.hwlp_end_addr_o   = end_q;
  assign hw.hwlp_counter_o    = cnt_q;
  assign hw.hwlp_dec_cnt_id_o = pend_q;

  always_comb begin
    hw.hwlp_active_o = '0;
    for (int i = 0; i < N_REGS; i++)
      hw.hwlp_active_o[i] = (cnt_q[i] != 32'd0);
  end

endmodule
